// File: rtl/fsm_ascon_drive_if.sv
// Bundle between the frame sequencer and the ASCON core / UART front-end.
// Requests are one-cycle pulses (init_o, data_valid_o). The core answers each one with a one-cycle end_* pulse, any
// number of cycles later. Only the end_* that matches the sequencer's current wait state is acted on.
interface fsm_ascon_drive_if;
  logic       start_i;
  logic       end_initialisation_i;
  logic       end_associate_i;
  logic       end_cipher_i;
  logic       end_tag_i;
  logic       init_o;
  logic       associate_data_o;
  logic       data_valid_o;
  logic       finalisation_o;
  logic       init_cpt_mux_o;
  logic       en_cpt_mux_o;
  logic       en_reg_ascon_o;
  logic [4:0] cpt_o;
  logic       busy_o;
  logic       done_o;
  logic [3:0] state_dbg;

  modport master (
    input  start_i, end_initialisation_i, end_associate_i, end_cipher_i, end_tag_i,
    output init_o, associate_data_o, data_valid_o, finalisation_o, init_cpt_mux_o,
           en_cpt_mux_o, en_reg_ascon_o, cpt_o, busy_o, done_o, state_dbg
  );

  modport slave (
    output start_i, end_initialisation_i, end_associate_i, end_cipher_i, end_tag_i,
    input  init_o, associate_data_o, data_valid_o, finalisation_o, init_cpt_mux_o,
           en_cpt_mux_o, en_reg_ascon_o, cpt_o, busy_o, done_o, state_dbg
  );
endinterface

// File: rtl/fsm_ascon_drive.sv
// Frame sequencer that drives one ASCON encryption per frame: init, associated data, NB_BLOCKS-1 data blocks,
// then a final block with tag. It also owns the block index that selects wave_s[cpt_o].
module fsm_ascon_drive #(
  parameter int NB_BLOCKS = 23
) (
  input logic               clock_i,
  input logic               reset_i,
  fsm_ascon_drive_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, INIT, WAIT_INIT, AD, WAIT_AD, DATA, WAIT_CIPHER, LAST, WAIT_TAG, DONE
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NB_BLOCKS - 1);
  localparam logic [4:0] NB_IDX   = 5'(NB_BLOCKS);

  state_t     state, state_nxt;
  logic [4:0] cpt;
  logic       clr_cpt, inc_cpt, store;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= IDLE;
      cpt   <= '0;
    end else begin
      state <= state_nxt;
      if (clr_cpt)
        cpt <= '0;
      else if (inc_cpt && cpt < NB_IDX)
        cpt <= cpt + 5'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_cpt   = 1'b0;
    inc_cpt   = 1'b0;
    store     = 1'b0;
    case (state)
      IDLE: if (bus.start_i) begin
        clr_cpt   = 1'b1;
        state_nxt = INIT;
      end
      INIT:      state_nxt = WAIT_INIT;
      WAIT_INIT: if (bus.end_initialisation_i) state_nxt = AD;
      AD:        state_nxt = WAIT_AD;
      // A one-block frame has no middle data blocks and goes straight to the final block.
      WAIT_AD: if (bus.end_associate_i) begin
        inc_cpt   = 1'b1;
        state_nxt = (NB_BLOCKS == 1) ? LAST : DATA;
      end
      DATA: state_nxt = WAIT_CIPHER;
      WAIT_CIPHER: if (bus.end_cipher_i) begin
        store     = 1'b1;
        inc_cpt   = 1'b1;
        state_nxt = (cpt == LAST_IDX) ? LAST : DATA;
      end
      LAST: state_nxt = WAIT_TAG;
      WAIT_TAG: if (bus.end_tag_i) begin
        store     = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The input-driven strobes are masked while reset is high, so reset overrides any concurrent event.
  assign bus.init_cpt_mux_o   = clr_cpt & ~reset_i;
  assign bus.en_cpt_mux_o     = inc_cpt & ~reset_i;
  assign bus.en_reg_ascon_o   = store & ~reset_i;
  assign bus.init_o           = (state == INIT);
  assign bus.associate_data_o = (state == AD) || (state == WAIT_AD);
  assign bus.data_valid_o     = (state == AD) || (state == DATA) || (state == LAST);
  assign bus.finalisation_o   = (state == LAST) || (state == WAIT_TAG);
  assign bus.busy_o           = (state != IDLE);
  assign bus.done_o           = (state == DONE);
  assign bus.cpt_o            = cpt;
  assign bus.state_dbg        = state;

endmodule

// File: tb/tb_fsm_ascon_drive.sv
// Bench for fsm_ascon_drive: a behavioural ASCON core answers requests, and a scoreboard checks every strobe cycle.
module tb_fsm_ascon_drive;
  localparam int NB = 23;
  localparam int W  = 13;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fsm_ascon_drive_if bus();
  fsm_ascon_drive_if bus2();

  fsm_ascon_drive #(.NB_BLOCKS(NB)) dut  (.clock_i(clk), .reset_i(rst), .bus(bus));
  fsm_ascon_drive #(.NB_BLOCKS(2))  dut2 (.clock_i(clk), .reset_i(rst), .bus(bus2));

  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int lat    = 3;
  bit spur   = 1'b0;
  logic [4:0] prev_cpt = 5'd0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Field order: init, assoc, dv, fin, init_cpt, en_cpt, en_reg, done, cpt
  function automatic logic [W-1:0] ev(bit i, bit a, bit d, bit f, bit ic, bit ec, bit er, bit dn, logic [4:0] c);
    return {i, a, d, f, ic, ec, er, dn, c};
  endfunction

  function automatic logic [W-1:0] obs_word();
    return {bus.init_o, bus.associate_data_o, bus.data_valid_o, bus.finalisation_o, bus.init_cpt_mux_o,
            bus.en_cpt_mux_o, bus.en_reg_ascon_o, bus.done_o, bus.cpt_o};
  endfunction

  // Expected strobe cycles of one frame; stop_k > 0 truncates after the data request at that index.
  task automatic push_frame(int stop_k);
    exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 0, 0, prev_cpt));
    exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0, 5'd0));
    exp_q.push_back(ev(0, 1, 1, 0, 0, 0, 0, 0, 5'd0));
    exp_q.push_back(ev(0, 1, 0, 0, 0, 1, 0, 0, 5'd0));
    for (int k = 1; k < NB; k++) begin
      exp_q.push_back(ev(0, 0, 1, 0, 0, 0, 0, 0, 5'(k)));
      if (k == stop_k) return;
      exp_q.push_back(ev(0, 0, 0, 0, 0, 1, 1, 0, 5'(k)));
    end
    exp_q.push_back(ev(0, 0, 1, 1, 0, 0, 0, 0, 5'(NB)));
    exp_q.push_back(ev(0, 0, 0, 1, 0, 0, 1, 0, 5'(NB)));
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 1, 5'(NB)));
    prev_cpt = 5'(NB);
  endtask

  // Monitor: every cycle with a strobe must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (bus.init_o | bus.data_valid_o | bus.init_cpt_mux_o | bus.en_cpt_mux_o |
                   bus.en_reg_ascon_o | bus.done_o)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_event: got %0h expected none at %0t", obs_word(), $time);
        end else begin
          check("event", 32'(obs_word()), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Behavioural ASCON core: answers each request 'lat' cycles later, optionally with spurious end_* noise.
  initial begin
    bit         pend = 1'b0;
    int         cnt  = 0;
    logic [3:0] kind = 4'b0001;
    logic [3:0] v;
    {bus.end_tag_i, bus.end_cipher_i, bus.end_associate_i, bus.end_initialisation_i} = 4'b0;
    forever begin
      @(posedge clk);
      #1;
      v = 4'b0;
      if (!bus.busy_o) pend = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          v    = spur ? 4'b1111 : kind;
          pend = 1'b0;
        end else if (spur) begin
          v = ~kind;
        end
      end
      {bus.end_tag_i, bus.end_cipher_i, bus.end_associate_i, bus.end_initialisation_i} = v;
      if (bus.init_o) begin
        pend = 1'b1; cnt = lat; kind = 4'b0001;
      end else if (bus.data_valid_o) begin
        pend = 1'b1; cnt = lat;
        kind = bus.associate_data_o ? 4'b0010 : (bus.finalisation_o ? 4'b1000 : 4'b0100);
      end
    end
  end

  // Zero-latency core for the two-block instance, plus its counters.
  int n_dv2 = 0, n_reg2 = 0, n_cpt2 = 0, n_done2 = 0;
  logic [4:0] fin_cpt2 = 5'd31;
  logic [4:0] dv_cpt2[$];
  initial begin
    logic p_init = 1'b0, p_ad = 1'b0, p_ci = 1'b0, p_tag = 1'b0;
    {bus2.end_tag_i, bus2.end_cipher_i, bus2.end_associate_i, bus2.end_initialisation_i} = 4'b0;
    forever begin
      @(posedge clk);
      #1;
      {bus2.end_tag_i, bus2.end_cipher_i, bus2.end_associate_i, bus2.end_initialisation_i} = {p_tag, p_ci, p_ad, p_init};
      p_init = bus2.init_o;
      p_ad   = bus2.data_valid_o & bus2.associate_data_o;
      p_ci   = bus2.data_valid_o & ~bus2.associate_data_o & ~bus2.finalisation_o;
      p_tag  = bus2.data_valid_o & bus2.finalisation_o;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus2.data_valid_o) begin
        n_dv2++;
        dv_cpt2.push_back(bus2.cpt_o);
        if (bus2.finalisation_o) fin_cpt2 = bus2.cpt_o;
      end
      if (bus2.en_reg_ascon_o) n_reg2++;
      if (bus2.en_cpt_mux_o)   n_cpt2++;
      if (bus2.done_o)         n_done2++;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 bus.start_i = 1'b1;
    @(posedge clk); #1 bus.start_i = 1'b0;
  endtask

  task automatic wait_done(string name);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic drain(string name);
    repeat (3) @(negedge clk);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit found = 1'b0;
    rst = 1'b1;
    bus.start_i  = 1'b0;
    bus2.start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(obs_word()), 32'd0);
    check("reset_busy", 32'(bus.busy_o), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Nominal frame, core latency 3.
    lat = 3; spur = 1'b0;
    push_frame(-1);
    pulse_start();
    wait_done("nominal");
    drain("nominal");

    // Core answering the cycle after each request.
    lat = 1;
    push_frame(-1);
    pulse_start();
    wait_done("zero_lat");
    drain("zero_lat");

    // Spurious and simultaneous end_* pulses.
    lat = 3; spur = 1'b1;
    push_frame(-1);
    pulse_start();
    wait_done("spurious");
    drain("spurious");
    spur = 1'b0;

    // start_i held across two frames, including the DONE cycle.
    lat = 1;
    push_frame(-1);
    push_frame(-1);
    @(posedge clk); #1 bus.start_i = 1'b1;
    wait_done("held_1");
    wait_done("held_2");
    bus.start_i = 1'b0;
    drain("held");

    // Reset while waiting for cipher block 10.
    lat = 3;
    push_frame(10);
    pulse_start();
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (bus.data_valid_o && !bus.associate_data_o && !bus.finalisation_o && bus.cpt_o == 5'd10) found = 1'b1;
    end
    check("reach_cpt10", 32'(found), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midreset_busy", 32'(bus.busy_o), 32'd0);
    check("midreset_cpt", 32'(bus.cpt_o), 32'd0);
    check("midreset_outputs", 32'(obs_word()), 32'd0);
    prev_cpt = 5'd0;
    drain("midreset");

    // A fresh frame after the abandoned one.
    push_frame(-1);
    pulse_start();
    wait_done("after_reset");
    drain("after_reset");

    // Two-block instance.
    @(posedge clk); #1 bus2.start_i = 1'b1;
    @(posedge clk); #1 bus2.start_i = 1'b0;
    for (int i = 0; i < 200 && n_done2 == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("nb2_done_count", 32'(n_done2), 32'd1);
    check("nb2_dv_count", 32'(n_dv2), 32'd3);
    check("nb2_reg_count", 32'(n_reg2), 32'd2);
    check("nb2_cpt_count", 32'(n_cpt2), 32'd2);
    check("nb2_fin_cpt", 32'(fin_cpt2), 32'd2);
    check("nb2_cpt_final", 32'(bus2.cpt_o), 32'd2);
    check("nb2_dv_cpt_len", 32'(dv_cpt2.size()), 32'd3);
    for (int i = 0; i < 3 && i < dv_cpt2.size(); i++) check("nb2_dv_cpt", 32'(dv_cpt2[i]), 32'(i));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fsm_ascon_drive.md
FSM_ASCON_DRIVE -- requirements
Module: fsm_ascon_drive

Interface
REQ-001 The block SHALL have parameter NB_BLOCKS, default 23, giving the number of 64-bit wave blocks per frame (wave_s index 1..NB_BLOCKS; index 0 = associated data).
REQ-002 The block SHALL have a single clock and a synchronous, active-high reset; port list follows.
REQ-003 clock_i  in  1  main clock; all state updates on rising edge.
REQ-004 reset_i  in  1  synchronous reset, active high.
REQ-005 start_i  in  1  frame ready from fsm_uart (Start_ascon); sampled in IDLE only.
REQ-006 end_initialisation_i  in  1  ASCON init permutation finished.
REQ-007 end_associate_i  in  1  ASCON AD absorption finished.
REQ-008 end_cipher_i  in  1  ASCON cipher block available on cipher bus.
REQ-009 end_tag_i  in  1  ASCON finalisation done, tag and last cipher block valid.
REQ-010 init_o  out  1  one-cycle start pulse to ASCON initialisation.
REQ-011 associate_data_o  out  1  AD phase indicator to ASCON.
REQ-012 data_valid_o  out  1  one-cycle pulse: data_s block presented to ASCON.
REQ-013 finalisation_o  out  1  last-block/finalisation indicator to ASCON.
REQ-014 init_cpt_mux_o  out  1  clears block counter and ascon_reg.
REQ-015 en_cpt_mux_o  out  1  counter increment strobe (mirrors internal increment).
REQ-016 en_reg_ascon_o  out  1  shift enable for ascon_reg (stores cipher_s).
REQ-017 cpt_o  out  5  block index driving the data_s mux (wave_s[cpt_o]).
REQ-018 busy_o  out  1  high in every state except IDLE.
REQ-019 done_o  out  1  one-cycle pulse when all NB_BLOCKS cipher words are stored.

Function
REQ-020 States SHALL be IDLE, INIT, WAIT_INIT, AD, WAIT_AD, DATA, WAIT_CIPHER, LAST, WAIT_TAG, DONE.
REQ-021 IDLE: start_i=1 -> INIT with init_cpt_mux_o=1 that cycle; cpt_o=0 from next cycle; otherwise stay.
REQ-022 INIT: init_o=1 for exactly one cycle -> WAIT_INIT.
REQ-023 WAIT_INIT: stay until end_initialisation_i=1 -> AD.
REQ-024 AD: associate_data_o=1, data_valid_o=1 for one cycle, cpt_o=0 -> WAIT_AD.
REQ-025 WAIT_AD: associate_data_o held 1; on end_associate_i=1, en_cpt_mux_o=1 (cpt_o 0->1) -> DATA.
REQ-026 DATA: data_valid_o=1 for one cycle -> WAIT_CIPHER.
REQ-027 WAIT_CIPHER: on end_cipher_i=1, en_reg_ascon_o=1 and en_cpt_mux_o=1 in the same cycle; next = LAST if cpt_o==NB_BLOCKS-1, else DATA.
REQ-028 LAST: finalisation_o=1, data_valid_o=1 for one cycle, cpt_o==NB_BLOCKS -> WAIT_TAG.
REQ-029 WAIT_TAG: finalisation_o held 1; on end_tag_i=1, en_reg_ascon_o=1 -> DONE.
REQ-030 DONE: done_o=1 for one cycle -> IDLE; cpt_o holds NB_BLOCKS until next start.
REQ-031 Per frame: exactly one init_o, NB_BLOCKS+1 data_valid_o, NB_BLOCKS en_reg_ascon_o, NB_BLOCKS en_cpt_mux_o pulses.
REQ-032 cpt_o SHALL never exceed NB_BLOCKS; increment in any other state is forbidden (no wrap).
REQ-033 start_i outside IDLE SHALL be ignored, including in DONE (accepted next cycle in IDLE if still high).
REQ-034 end_* inputs arriving outside their wait state SHALL be ignored; simultaneous end_* inputs act only on the one matching the current state.
REQ-035 All outputs SHALL be registered or decoded from state only (no combinational path from end_* to outputs except REQ-025/027/029 strobes).

Reset
REQ-036 reset_i=1 at any clock edge SHALL force IDLE, cpt_o=0, every 1-bit output 0, overriding any concurrent event.
REQ-037 Reset mid-frame SHALL abandon the frame with no done_o; next start_i begins a full new frame.

Verification
REQ-038 Nominal frame: start_i pulse, end_* each 3 cycles after request -> 24 data_valid_o, 23 en_reg_ascon_o, done_o once, cpt_o sequence 0,1..23.
REQ-039 Zero-latency core: end_* asserted the cycle after each request -> frame completes, counts as REQ-031, no missed strobes.
REQ-040 start_i held high for whole frame -> second frame starts the cycle after DONE; no restart mid-frame.
REQ-041 Spurious end_cipher_i in WAIT_INIT and end_tag_i in WAIT_CIPHER -> state, cpt_o and strobes unchanged.
REQ-042 reset_i asserted in WAIT_CIPHER with cpt_o=10 -> next cycle IDLE, cpt_o=0, busy_o=0; no done_o.
REQ-043 NB_BLOCKS=2 build -> cpt_o 0,1,2; finalisation_o at cpt_o=2; 2 en_reg_ascon_o pulses.
